decoder_rr_arbiter: RTL and testbench
=====================================

Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource between 16 requesters.
- Issues one-hot grants through the team's 4-to-16 decoder, which is instantiated inside the block.
- Sits in front of a shared resource such as a bus slave or a memory port. Each requester raises req and the granted requester signals done.
- Has a fairness pointer and a hold-timeout so no owner can starve the others.

Parameters:
- TIMEOUT, 64: maximum number of consecutive GRANT cycles per owner. A value of 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  arbitration enable; when low, no new grants are issued.
- req  input  16  request vector; bit i is requester i.
- done  input  1  the current owner has finished; sampled only in GRANT.
- grant  output  16  one-hot grant; equals the decode of grant_idx when grant_valid=1, and all zeros otherwise.
- grant_idx  output  4  index of the current owner.
- grant_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by the timer.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE; grant=0, grant_idx=0, grant_valid=0, timeout=0; pointer last_idx=4'd15; timer=0.
  - Reset deasserted mid-grant drops the grant immediately. No done or timeout is generated.
- FSM states: IDLE, GRANT.
- IDLE:
  - grant_valid=0.
  - If ena=1 and req!=0, select the first set bit searching upward from (last_idx+1) mod 16, wrapping 15->0.
  - On the next edge: state=GRANT, grant_idx=winner, grant_valid=1, timer=0.
  - If ena=0 or req=0: remain in IDLE.
  - Latency: req sampled at edge N gives grant visible after edge N.
- GRANT, evaluated each edge in priority order:
  1. done=1 -> release.
  2. req[grant_idx]=0 -> release (requester abandoned).
  3. TIMEOUT!=0 and timer==TIMEOUT-1 -> release and assert timeout for one cycle.
  4. Otherwise timer increments and the grant holds.
- Release:
  - On the releasing edge: state=IDLE, grant_valid=0, grant=0, last_idx=grant_idx.
  - IDLE always lasts at least one cycle, giving a mandatory one-cycle dead gap between owners.
  - Minimum owner-to-owner turnaround: release edge E, next grant after edge E+1.
- Simultaneous conditions:
  - done and timer expiry on the same edge -> treated as done; no timeout pulse.
  - ena has no effect in GRANT; the current owner keeps its grant until release.
  - Changes on req bits other than the owner's are ignored during GRANT.
  - A lone requester that keeps requesting is re-granted after the one-cycle gap, because the wrap search reaches it.
- Timer and pointer widths:
  - Timer is $clog2(TIMEOUT+1) bits and saturates logically through the release rule; it never wraps.
  - last_idx is 4 bits and wraps naturally.
- Output generation:
  - grant is produced by the decoder from grant_idx, enabled by grant_valid.
  - grant is always zero or exactly one-hot, never multi-hot.
  - All outputs are registered or derived combinationally only from registered state, never from req.

Test Plan:
- Single request: after reset, req=16'h0020, ena=1 -> after 1 edge, grant=16'h0020, grant_idx=5, grant_valid=1. Pulse done -> grant=0 for 1 cycle, then grant=16'h0020 again if req is still high.
- Full contention: req=16'hFFFF, done pulsed 2 cycles after each grant -> owners 0,1,2,...,15,0 in order, each separated by exactly one zero-grant cycle.
- Fairness pointer: finish a grant to index 3, then req=16'h0202 -> grant index 9 first, then index 1 after the gap.
- Timeout: TIMEOUT=4, req[2] held, done=0 -> grant_valid high for exactly 4 cycles, timeout=1 coincident with the drop for one cycle, then re-grant of 2. With done=1 on the 4th cycle instead -> no timeout pulse.
- Enable and abandon:
  - ena=0 with req=16'h0001 -> no grant ever issued.
  - ena dropped during an active grant -> grant persists until done.
  - Owner deasserts its req bit -> grant drops on the next edge without any timeout pulse.
- Reset mid-grant: rst_n low while grant=16'h0100 -> all outputs 0 asynchronously, without waiting for clk. After release, req=16'hFFFF -> first grant goes to index 0.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 16 requesters sharing one resource.
// Grants are issued one-hot through a 4-to-16 decoder. A fairness
// pointer (last_idx) rotates priority past the previous owner, and a
// hold timer bounds how long any owner may keep the resource.

// 4-to-16 one-hot decoder with enable; output is all zeros when disabled.
module decoder_4to16 (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] dec
);

    // Drive exactly one bit when enabled, none otherwise.
    always_comb begin
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; searches req upward from last_idx+1 when ena=1
// GRANT | grant_idx owns the resource until done, abandon or timer expiry
module decoder_rr_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic [3:0]  grant_idx,
    output logic        grant_valid,
    output logic        timeout
);

    // A zero TIMEOUT still needs a legal one-bit timer; it is never compared.
    localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TC_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [TW-1:0] TC = TW'(TC_INT);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    grant_idx_q;
    logic [3:0]    last_idx_q;
    logic [TW-1:0] timer_q;
    logic          timeout_q;

    logic          pick_valid;
    logic [3:0]    pick_idx;
    logic [3:0]    cand;
    logic          rel_done;
    logic          rel_abandon;
    logic          rel_timer;
    logic          release_now;

    // Rotating priority search starting just above the previous owner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 4'd0;
        cand       = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cand = last_idx_q + 4'd1 + 4'(i);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Release causes in priority order: done beats abandon beats timer.
    always_comb begin
        rel_done    = done;
        rel_abandon = !done && !req[grant_idx_q];
        rel_timer   = !done && req[grant_idx_q] &&
                      (TIMEOUT != 0) && (timer_q == TC);
        release_now = rel_done || rel_abandon || rel_timer;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; IDLE always lasts at least one cycle after a release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ena && pick_valid) state_d = GRANT;
            GRANT:   if (release_now)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Owner index, fairness pointer, hold timer and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_idx_q <= 4'd0;
            last_idx_q  <= 4'd15;
            timer_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == IDLE) begin
                if (ena && pick_valid) begin
                    grant_idx_q <= pick_idx;
                    timer_q     <= '0;
                end
            end else begin
                if (release_now) begin
                    last_idx_q <= grant_idx_q;
                    timeout_q  <= rel_timer;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end
        end
    end

    // Outputs come only from registered state.
    always_comb begin
        grant_valid = (state_q == GRANT);
        grant_idx   = grant_idx_q;
        timeout     = timeout_q;
    end

    decoder_4to16 u_dec (
        .sel (grant_idx_q),
        .en  (grant_valid),
        .dec (grant)
    );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter (built with TIMEOUT=4).
module tb_decoder_rr_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    int checks;
    int failures;

    // Reference model: owner (-1 = none), cycles held, last owner, pulse.
    int m_owner;
    int m_held;
    int m_last;
    bit m_to;

    typedef struct {
        bit          ena;
        logic [15:0] req;
        bit          done;
        logic [15:0] exp_grant;
        bit          exp_to;
    } vec_t;

    vec_t vecs[26];

    decoder_rr_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 15;
        m_to    = 1'b0;
    endtask

    // One clock edge of the arbitration rules, applied to current inputs.
    task automatic model_edge();
        int c;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (ena && req != 16'h0) begin
                for (int k = 1; k <= 16; k++) begin
                    c = (m_last + k) % 16;
                    if (req[c] && m_owner < 0) begin
                        m_owner = c;
                        m_held  = 1;
                    end
                end
            end
        end else if (done || !req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (TO != 0 && m_held == TO) begin
            m_last  = m_owner;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] eg;
        eg = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
        if (m_owner >= 0) chk({tag, ".idx"}, 32'(grant_idx), 32'(m_owner));
    endtask

    // Advance one clock, update the model, sample away from the edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'h0);
        chk({tag, ".idx"}, 32'(grant_idx), 32'h0);
        chk({tag, ".valid"}, 32'(grant_valid), 32'h0);
        chk({tag, ".timeout"}, 32'(timeout), 32'h0);
    endtask

    function automatic int onehot_idx(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        ena   = 1'b0;
        req   = 16'h0;
        done  = 1'b0;
        model_reset();

        //        ena  req       done exp_grant  to
        vecs[0]  = '{1, 16'h0020, 0, 16'h0020, 0};  // single request
        vecs[1]  = '{1, 16'h0020, 1, 16'h0000, 0};  // done -> gap
        vecs[2]  = '{1, 16'h0020, 0, 16'h0020, 0};  // lone requester re-granted
        vecs[3]  = '{1, 16'h0000, 0, 16'h0000, 0};  // abandon, no timeout
        vecs[4]  = '{1, 16'h0000, 0, 16'h0000, 0};
        vecs[5]  = '{1, 16'h0004, 0, 16'h0004, 0};  // timeout run: 4 grant cycles
        vecs[6]  = '{1, 16'h0004, 0, 16'h0004, 0};
        vecs[7]  = '{1, 16'h0004, 0, 16'h0004, 0};
        vecs[8]  = '{1, 16'h0004, 0, 16'h0004, 0};
        vecs[9]  = '{1, 16'h0004, 0, 16'h0000, 1};  // timer revokes
        vecs[10] = '{1, 16'h0004, 0, 16'h0004, 0};  // re-grant
        vecs[11] = '{1, 16'h0004, 0, 16'h0004, 0};
        vecs[12] = '{1, 16'h0004, 0, 16'h0004, 0};
        vecs[13] = '{1, 16'h0004, 0, 16'h0004, 0};
        vecs[14] = '{1, 16'h0004, 1, 16'h0000, 0};  // done wins over expiry
        vecs[15] = '{0, 16'h0001, 0, 16'h0000, 0};  // ena low: no grant
        vecs[16] = '{0, 16'h0001, 0, 16'h0000, 0};
        vecs[17] = '{1, 16'h0001, 0, 16'h0001, 0};
        vecs[18] = '{0, 16'h0001, 0, 16'h0001, 0};  // ena ignored in GRANT
        vecs[19] = '{0, 16'h0001, 1, 16'h0000, 0};
        vecs[20] = '{1, 16'h0008, 0, 16'h0008, 0};  // owner 3
        vecs[21] = '{1, 16'h0008, 1, 16'h0000, 0};
        vecs[22] = '{1, 16'h0202, 0, 16'h0200, 0};  // pointer: 9 before 1
        vecs[23] = '{1, 16'h0202, 1, 16'h0000, 0};
        vecs[24] = '{1, 16'h0202, 0, 16'h0002, 0};
        vecs[25] = '{1, 16'h0202, 1, 16'h0000, 0};

        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            ena  = vecs[i].ena;
            req  = vecs[i].req;
            done = vecs[i].done;
            step($sformatf("vec%0d.model", i));
            chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            chk($sformatf("vec%0d.timeout", i), 32'(timeout), 32'(vecs[i].exp_to));
            if (vecs[i].exp_grant != 16'h0)
                chk($sformatf("vec%0d.idx", i), 32'(grant_idx), 32'(onehot_idx(vecs[i].exp_grant)));
        end

        // Reset mid-grant: go to a fresh reset, grant 8, then async reset.
        ena = 1'b1; req = 16'h0; done = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        req = 16'h0100;
        step("rstmid.pre");
        chk("rstmid.grant_before", 32'(grant), 32'h0100);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rstmid.async");
        @(negedge clk);
        rst_n = 1'b1;
        req = 16'hFFFF;
        step("contend.first");
        chk("contend.first_idx", 32'(grant_idx), 32'h0);

        // Full contention: owners rotate 0..15,0 with one empty cycle between.
        for (int k = 0; k <= 16; k++) begin
            chk($sformatf("contend%0d.idx", k), 32'(grant_idx), 32'(k % 16));
            chk($sformatf("contend%0d.valid", k), 32'(grant_valid), 32'h1);
            done = 1'b0;
            step($sformatf("contend%0d.hold", k));
            done = 1'b1;
            step($sformatf("contend%0d.rel", k));
            chk($sformatf("contend%0d.gap", k), 32'(grant), 32'h0);
            done = 1'b0;
            step($sformatf("contend%0d.next", k));
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            ena  = ($urandom_range(0, 7) != 0);
            req  = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) req = 16'h0;
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) req[m_owner] = 1'b1;
            done = ($urandom_range(0, 4) == 0);
            step($sformatf("rand%0d", n));
            if (grant != 16'h0 && (grant & (grant - 16'h1)) != 16'h0)
                chk($sformatf("rand%0d.onehot", n), 32'(grant), 32'(16'h1 << grant_idx));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
